// File: rtl/hash_tx_scheduler_pkg.sv
// Shared definitions for the hash transmit scheduler: FSM encoding,
// byte width and a constant-evaluable ceil(log2) helper.
package hash_tx_scheduler_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hash_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or above
// the pointer, wrapping to the lowest set request when none lies above it.
module hash_tx_scheduler_rr_arbiter
  import hash_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);

  logic any_req;

  assign any_req = |req;

  // Lowest set request overall, overridden by the lowest set request >= ptr.
  always_comb begin
    grant_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant_id = IDW'(k);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k] && (IDW'(k) >= ptr)) begin
        grant_id = IDW'(k);
      end
    end
  end

  // One-hot grant derived from the chosen index; empty when nobody asks.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = any_req && (grant_id == IDW'(gi));
  end

endmodule

// File: rtl/hash_tx_scheduler.sv
// Shares one byte-serial transmit channel between NUM_REQ hash producers.
// A granted hash is latched, sent LSB byte first over valid/ready, and the
// requester is then acknowledged with a one-cycle pulse.
module hash_tx_scheduler
  import hash_tx_scheduler_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int HASH_W  = 64,
  localparam int IDW     = clog2(NUM_REQ)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*HASH_W-1:0] Hash,
  output logic [NUM_REQ-1:0]        Ack,
  output logic [BYTE_W-1:0]         Byte,
  output logic                      ByteValid,
  input  logic                      ByteReady,
  output logic                      First,
  output logic                      Last,
  output logic                      Busy,
  output logic [IDW-1:0]            GrantId
);

  localparam int NBYTES = HASH_W / BYTE_W;
  localparam int CW     = (clog2(NBYTES) < 1) ? 1 : clog2(NBYTES);

  state_t              state_reg, state_next;
  logic [IDW-1:0]      ptr_reg;
  logic [IDW-1:0]      grant_reg;
  logic [CW-1:0]       count_reg;
  logic [HASH_W-1:0]   shift_reg;
  logic [HASH_W-1:0]   hash_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDW-1:0]      arb_id;
  logic                req_any;
  logic                last_beat;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hash
    assign hash_arr[gi] = Hash[gi*HASH_W +: HASH_W];
  end

  hash_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req      (Req),
    .ptr      (ptr_reg),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  assign req_any   = |arb_grant;
  assign last_beat = (count_reg == CW'(NBYTES - 1));
  assign Busy      = (state_reg != IDLE);
  assign GrantId   = grant_reg;

  // State register; reset aborts any frame in flight without an Ack.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and output decode from the current state.
  always_comb begin
    state_next = state_reg;
    Ack        = '0;
    Byte       = '0;
    ByteValid  = 1'b0;
    First      = 1'b0;
    Last       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          state_next = SEND;
        end
      end
      SEND: begin
        ByteValid = 1'b1;
        Byte      = shift_reg[BYTE_W-1:0];
        First     = (count_reg == '0);
        Last      = last_beat;
        if (ByteReady && last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        Ack[grant_reg] = 1'b1;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch hash on grant, shift per accepted byte, advance pointer.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ptr_reg   <= '0;
      grant_reg <= '0;
      count_reg <= '0;
      shift_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            shift_reg <= hash_arr[arb_id];
            grant_reg <= arb_id;
            count_reg <= '0;
          end
        end
        SEND: begin
          if (ByteReady) begin
            shift_reg <= shift_reg >> BYTE_W;
            count_reg <= count_reg + 1'b1;
          end
        end
        DONE: begin
          ptr_reg <= (grant_reg == IDW'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_tx_scheduler.sv
// Bench for hash_tx_scheduler: directed scenarios followed by random traffic,
// all checked each cycle against a frame-queue reference model.
module tb_hash_tx_scheduler;

  localparam int NUM_REQ = 2;
  localparam int HASH_W  = 64;
  localparam int NBYTES  = HASH_W / 8;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*HASH_W-1:0] hash;
  logic [NUM_REQ-1:0]        ack;
  logic [7:0]                byte_out;
  logic                      byte_valid;
  logic                      byte_ready;
  logic                      first;
  logic                      last;
  logic                      busy;
  logic [0:0]                grant_id;

  hash_tx_scheduler #(
    .NUM_REQ (NUM_REQ),
    .HASH_W  (HASH_W)
  ) dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .Req       (req),
    .Hash      (hash),
    .Ack       (ack),
    .Byte      (byte_out),
    .ByteValid (byte_valid),
    .ByteReady (byte_ready),
    .First     (first),
    .Last      (last),
    .Busy      (busy),
    .GrantId   (grant_id)
  );

  always #5 clk = ~clk;

  // Reference model: bytes still owed for the current frame, the pending Ack,
  // the requester that starts the next priority search, and the last grant.
  logic [7:0] m_q [$];
  int         m_ack = -1;
  int         m_ptr = 0;
  int         m_gid = 0;
  bit         auto_drop = 1'b1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic model_step();
    logic [63:0] h;
    bit          found;
    int          k;
    if (!rst_n) begin
      m_q.delete();
      m_ack = -1;
      m_ptr = 0;
      m_gid = 0;
    end else if (m_ack >= 0) begin
      m_ptr = (m_ack + 1) % NUM_REQ;
      m_ack = -1;
    end else if (m_q.size() > 0) begin
      if (byte_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_ack = m_gid;
      end
    end else begin
      found = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
        k = (m_ptr + off) % NUM_REQ;
        if (!found && req[k]) begin
          found = 1'b1;
          h = hash[k*HASH_W +: HASH_W];
          for (int b = 0; b < NBYTES; b++) m_q.push_back(h[8*b +: 8]);
          m_gid = k;
        end
      end
    end
  endtask

  // One clock: update model, let the edge happen, compare on the falling edge.
  task automatic cycle();
    logic [63:0] exp_ack;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp_ack = '0;
    if (m_ack >= 0) exp_ack[m_ack] = 1'b1;
    check_eq("valid", {63'd0, byte_valid}, {63'd0, m_q.size() > 0});
    if (m_q.size() > 0) check_eq("byte", {56'd0, byte_out}, {56'd0, m_q[0]});
    check_eq("first", {63'd0, first}, {63'd0, m_q.size() == NBYTES});
    check_eq("last", {63'd0, last}, {63'd0, m_q.size() == 1});
    check_eq("ack", {62'd0, ack}, exp_ack);
    check_eq("busy", {63'd0, busy}, {63'd0, (m_q.size() > 0) || (m_ack >= 0)});
    check_eq("gid", {63'd0, grant_id}, 64'(m_gid));
    if (m_ack >= 0) begin
      $display("frame acked requester=%0d", m_ack);
      if (auto_drop) req[m_ack] = 1'b0;
    end
  endtask

  task automatic set_hash(input int k, input logic [63:0] value);
    hash[k*HASH_W +: HASH_W] = value;
  endtask

  int rr_n;
  int pat;

  initial begin
    rst_n      = 1'b0;
    req        = 2'b11;
    hash       = '0;
    byte_ready = 1'b1;

    // Reset held with both requests pending: nothing may start.
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("rst_byte", {56'd0, byte_out}, 64'd0);
    end
    rst_n = 1'b1;
    req   = 2'b00;
    cycle();

    // Single frame, ready always high.
    set_hash(0, 64'h0807060504030201);
    req = 2'b01;
    for (int i = 0; i < NBYTES; i++) begin
      cycle();
      check_eq("sf_byte", {56'd0, byte_out}, 64'(i + 1));
    end
    cycle();
    check_eq("sf_ack", {62'd0, ack}, 64'd1);
    cycle();

    // Same frame under a 1,0,0,1 ready pattern.
    req = 2'b01;
    for (int i = 0; i < 40; i++) begin
      pat        = i % 4;
      byte_ready = (pat == 0) || (pat == 3);
      cycle();
    end
    byte_ready = 1'b1;

    // Round robin with both requests held throughout.
    rst_n     = 1'b0;
    auto_drop = 1'b0;
    req       = 2'b11;
    set_hash(0, 64'hAAAA_AAAA_AAAA_AAAA);
    set_hash(1, 64'h5555_5555_5555_5555);
    cycle();
    rst_n = 1'b1;
    rr_n  = 0;
    for (int i = 0; i < 42; i++) begin
      cycle();
      if (m_q.size() == NBYTES) begin
        check_eq("rr_gid", {63'd0, grant_id}, 64'(rr_n % 2));
        rr_n++;
      end
    end
    check_eq("rr_frames", 64'(rr_n), 64'd5);
    auto_drop = 1'b1;
    req       = 2'b00;
    for (int i = 0; i < 12; i++) cycle();

    // Reset mid-frame after byte 03 is presented; frame restarts afterwards.
    set_hash(0, 64'h0807060504030201);
    req = 2'b01;
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b0;
    cycle();
    check_eq("mr_valid", {63'd0, byte_valid}, 64'd0);
    check_eq("mr_ack", {62'd0, ack}, 64'd0);
    rst_n = 1'b1;
    cycle();
    check_eq("mr_byte", {56'd0, byte_out}, 64'h01);
    check_eq("mr_first", {63'd0, first}, 64'd1);
    for (int i = 0; i < 12; i++) cycle();

    // Hash altered right after the grant edge must not reach the link.
    set_hash(0, {$urandom, $urandom});
    req = 2'b01;
    cycle();
    set_hash(0, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 11; i++) cycle();

    // Random traffic with backpressure, early Req drops and rare resets.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!req[k] && ($urandom_range(0, 3) == 0)) req[k] = 1'b1;
        if (!req[k] || ($urandom_range(0, 7) == 0)) set_hash(k, {$urandom, $urandom});
      end
      if ($urandom_range(0, 59) == 0) req[$urandom_range(0, NUM_REQ - 1)] = 1'b0;
      byte_ready = ($urandom_range(0, 3) != 0);
      rst_n      = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_tx_scheduler.md
Name: hash_tx_scheduler

Overview:
- Round-robin scheduler that shares one byte-serial hash transmit channel between NUM_REQ hash producers.
- Grants one requester at a time and latches its HASH_W-bit hash. Sends the hash LSB byte first over a valid/ready byte interface, then acknowledges the requester.
- Sits between the hash generators and the downstream byte link, and owns all sequencing of the serialiser.

Parameters:
NUM_REQ, 2, number of requesting hash producers (>=2)
HASH_W, 64, hash width in bits; must be a multiple of 8
NBYTES, HASH_W/8, derived localparam; bytes per frame

Ports:
Clock  input  1  single system clock, rising edge
Reset  input  1  synchronous, active-low reset (asserted when 0)
Req  input  NUM_REQ  per-requester request; held high until matching Ack
Hash  input  NUM_REQ*HASH_W  flattened hashes; requester k occupies bits [k*HASH_W +: HASH_W]
Ack  output  NUM_REQ  one-cycle pulse to the granted requester after its last byte transfers
Byte  output  8  current byte of frame
ByteValid  output  1  Byte is valid
ByteReady  input  1  downstream accepts Byte this cycle
First  output  1  high with ByteValid on byte 0 of frame
Last  output  1  high with ByteValid on byte NBYTES-1
Busy  output  1  frame in progress (SEND or DONE state)
GrantId  output  clog2(NUM_REQ)  index of current/last granted requester

Behaviour:
- Reset == 0 at a rising edge forces the following, regardless of state:
  - state IDLE; Byte=0, ByteValid=0, First=0, Last=0, Busy=0, Ack=0, GrantId=0.
  - round-robin pointer=0; byte counter=0; shift register=0.
  - A reset mid-frame aborts the frame. No Ack is issued for it; the requester keeps Req high and is regranted later.
- States: IDLE, SEND, DONE.
- IDLE:
  - If any Req bit is set, grant the first set bit searching from the pointer upward with wrap-around.
  - Load that requester's Hash into the shift register, set GrantId, clear the counter, go to SEND.
  - If no Req bit is set, stay in IDLE.
- SEND:
  - ByteValid=1; Byte=shift[7:0]; First=(count==0); Last=(count==NBYTES-1).
  - On ByteValid & ByteReady: shift right by 8 and count+1. If count was NBYTES-1, go to DONE.
  - While ByteReady=0: Byte, First and Last hold stable; no shifting.
- DONE:
  - ByteValid=0; Ack[GrantId]=1 for exactly this cycle.
  - Pointer = GrantId+1, wrapping to 0 at NUM_REQ. Go to IDLE.
- Latency with ByteReady tied high: Req seen in IDLE at edge t gives byte0 valid in cycle t+1 and byte NBYTES-1 in cycle t+NBYTES.
  - Ack is in cycle t+NBYTES+1.
  - The next grant is decided in IDLE at cycle t+NBYTES+2.
- Hash is sampled only on the grant edge. Later changes to Hash or Req from the granted requester do not affect the frame in flight.
- A Req deasserting mid-frame does not abort the frame; Ack is still issued.
- Requests arriving during SEND or DONE wait for IDLE.
- Fairness: after serving k, requester k has lowest priority for the next grant.
- Busy = (state != IDLE).
- Exactly one Ack bit is high at any time, or none. Ack never coincides with ByteValid.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, SEND=2'd1, DONE=2'd2;
  - BYTE_W=8;
  - a clog2 helper function.
- One natural sub-module, rr_arbiter: combinational grant from Req plus pointer, outputting a one-hot grant and its index.
- Shift register, counter and FSM stay in hash_tx_scheduler.

Test Plan:
- Reset: hold Reset=0 for 3 cycles with Req=2'b11 -> all outputs 0 and GrantId=0; Busy stays 0 through reset.
- Single frame: Req=2'b01, Hash[63:0]=64'h0807060504030201, ByteReady=1.
  - Bytes 01,02,...,08 appear on consecutive cycles, First on 01 and Last on 08.
  - Ack=2'b01 one cycle after the 08 byte.
- Backpressure: same frame with ByteReady toggling 1,0,0,1,...
  - Byte stays stable while ready is low; exactly 8 transfers in order 01..08; Ack only after the 8th transfer.
- Round-robin: Req=2'b11 held continuously, hash0=64'hAAAA..., hash1=64'h5555...
  - Frames alternate GrantId 0,1,0,1; each Ack matches the sending requester.
- Reset mid-frame: pull Reset low after byte 3 of a frame.
  - ByteValid=0 on the next cycle and no Ack is issued.
  - After release with Req held, the frame restarts from byte 01 with First=1.
- Hash change after grant: alter Hash0 to 64'hFFFF... during SEND -> the transmitted bytes still equal the originally latched value.
